// File: rtl/rd_wb_pipe_pkg.sv
// Shared opcode and write-back source encodings for the Rd write-back pipeline.
// Imported by the ID decoder and the stage pipe so both agree on the select codes.
package rd_wb_pipe_pkg;

  localparam int WB_SEL_W = 3;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    WB_SEL_LINK  = 3'b000,
    WB_SEL_AUIPC = 3'b001,
    WB_SEL_LUI   = 3'b010,
    WB_SEL_ALU   = 3'b011,
    WB_SEL_MEM   = 3'b100,
    WB_SEL_NONE  = 3'b111
  } wb_sel_e;

  // Compressed jumps link to the next 16-bit parcel rather than the next word.
  function automatic int unsigned linkOffset(input logic isC);
    return isC ? 32'd2 : 32'd4;
  endfunction

endpackage

// File: rtl/rd_wb_pipe_sel_decode.sv
// Maps inst[6:2] to the write-back source select; purely combinational.
module rd_wb_pipe_sel_decode
  import rd_wb_pipe_pkg::*;
#(
  parameter int SEL_W = WB_SEL_W
) (
  input  logic [4:0]       opcode_i,
  output logic [SEL_W-1:0] sel_o
);

  always_comb begin
    sel_o = SEL_W'(WB_SEL_NONE);
    case (opcode_i)
      OPCODE_JAL, OPCODE_JALR: sel_o = SEL_W'(WB_SEL_LINK);
      OPCODE_AUIPC:            sel_o = SEL_W'(WB_SEL_AUIPC);
      OPCODE_LUI:              sel_o = SEL_W'(WB_SEL_LUI);
      OPCODE_OP, OPCODE_OP_IMM: sel_o = SEL_W'(WB_SEL_ALU);
      OPCODE_LOAD:             sel_o = SEL_W'(WB_SEL_MEM);
      default:                 sel_o = SEL_W'(WB_SEL_NONE);
    endcase
  end

endmodule

// File: rtl/rd_wb_pipe.sv
// Carries the decoded write-back source with rd/pc/imm through STAGES register slices
// and drives the register-file write port from the last (WB) slice.
module rd_wb_pipe
  import rd_wb_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int SEL_W  = WB_SEL_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [4:0]            id_opcode_i,
  input  logic [4:0]            id_rd_i,
  input  logic                  id_is_c_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       wb_alu_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  rd_we_o,
  output logic [4:0]            rd_addr_o,
  output logic [XLEN-1:0]       rd_wdata_o,
  output logic                  wb_wait_o,
  output logic [STAGES-1:0]     stg_wr_o,
  output logic [5*STAGES-1:0]   stg_rd_o
);

  localparam int WB = STAGES - 1;

  logic [SEL_W-1:0]                idSel;
  logic                            idWr;
  logic [STAGES-1:0]               stgValid_q, stgValid_d;
  logic [STAGES-1:0]               stgWr_q;
  logic [STAGES-1:0]               stgIsC_q;
  logic [STAGES-1:0][SEL_W-1:0]    stgSel_q;
  logic [STAGES-1:0][4:0]          stgRd_q;
  logic [STAGES-1:0][XLEN-1:0]     stgPc_q;
  logic [STAGES-1:0][XLEN-1:0]     stgImm_q;
  logic                            advance;
  logic                            wbIsMem;
  logic [XLEN-1:0]                 wbData;

  rd_wb_pipe_sel_decode #(
    .SEL_W (SEL_W)
  ) u_sel_decode (
    .opcode_i (id_opcode_i),
    .sel_o    (idSel)
  );

  assign idWr = (idSel != SEL_W'(WB_SEL_NONE)) && (id_rd_i != 5'd0);

  assign wbIsMem   = stgValid_q[WB] && (stgSel_q[WB] == SEL_W'(WB_SEL_MEM));
  assign wb_wait_o = wbIsMem && !mem_rvalid_i;
  assign advance   = !stall_i && !wb_wait_o;

  assign rd_we_o = stgValid_q[WB] && stgWr_q[WB] && !stall_i && (!wbIsMem || mem_rvalid_i);

  // Flush kills everything younger than WB, whether the pipe moves or holds.
  always_comb begin
    stgValid_d = stgValid_q;
    if (advance) begin
      stgValid_d[0] = id_valid_i && !flush_i;
      for (int i = 1; i < STAGES; i++) begin
        stgValid_d[i] = stgValid_q[i-1] && !flush_i;
      end
    end else if (flush_i) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        stgValid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stgValid_q <= '0;
      stgWr_q    <= '0;
      stgIsC_q   <= '0;
      stgSel_q   <= '0;
      stgRd_q    <= '0;
      stgPc_q    <= '0;
      stgImm_q   <= '0;
    end else begin
      stgValid_q <= stgValid_d;
      if (advance) begin
        stgWr_q[0]  <= idWr;
        stgIsC_q[0] <= id_is_c_i;
        stgSel_q[0] <= idSel;
        stgRd_q[0]  <= id_rd_i;
        stgPc_q[0]  <= id_pc_i;
        stgImm_q[0] <= id_imm_i;
        for (int i = 1; i < STAGES; i++) begin
          stgWr_q[i]  <= stgWr_q[i-1];
          stgIsC_q[i] <= stgIsC_q[i-1];
          stgSel_q[i] <= stgSel_q[i-1];
          stgRd_q[i]  <= stgRd_q[i-1];
          stgPc_q[i]  <= stgPc_q[i-1];
          stgImm_q[i] <= stgImm_q[i-1];
        end
      end
    end
  end

  always_comb begin
    wbData = '0;
    case (stgSel_q[WB])
      SEL_W'(WB_SEL_LINK):  wbData = stgPc_q[WB] + XLEN'(linkOffset(stgIsC_q[WB]));
      SEL_W'(WB_SEL_AUIPC): wbData = stgPc_q[WB] + stgImm_q[WB];
      SEL_W'(WB_SEL_LUI):   wbData = stgImm_q[WB];
      SEL_W'(WB_SEL_ALU):   wbData = wb_alu_i;
      SEL_W'(WB_SEL_MEM):   wbData = mem_rdata_i;
      default:              wbData = '0;
    endcase
  end

  assign rd_addr_o  = stgValid_q[WB] ? stgRd_q[WB] : 5'd0;
  assign rd_wdata_o = stgValid_q[WB] ? wbData : '0;
  assign stg_wr_o   = stgValid_q & stgWr_q;

  // Empty stages report rd as zero so the hazard unit never sees stale numbers.
  always_comb begin
    stg_rd_o = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (stgValid_q[i]) begin
        stg_rd_o[5*i +: 5] = stgRd_q[i];
      end
    end
  end

endmodule
